// File: rtl/hash_host_bridge.sv
// rtl/hash_host_bridge.sv - byte-serial host bridge to a double-SHA256 core with header cache and nonce sweep
module hash_host_bridge #(
    parameter int BUS_W     = 8,
    parameter int WORD_W    = 32,
    parameter int HDR_WORDS = 20,
    parameter int HASH_W    = 256,
    parameter int NONCE_IDX = 19,
    parameter int AW        = 5,
    parameter int TW        = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_start,
    input  logic              host_mode,
    input  logic [TW-1:0]     host_target,
    input  logic              host_rdy,
    input  logic [BUS_W-1:0]  host_data,
    output logic              host_rq,
    output logic [BUS_W-1:0]  host_out,
    output logic              done,
    output logic              found,
    output logic              busy,
    output logic              core_start,
    input  logic              core_rq,
    input  logic [AW-1:0]     core_addr,
    output logic              core_rdy,
    output logic [WORD_W-1:0] core_data,
    input  logic [HASH_W-1:0] core_hash,
    input  logic              core_done
);

    localparam int BPW        = WORD_W / BUS_W;
    localparam int LOAD_BYTES = HDR_WORDS * BPW;
    localparam int HASH_BYTES = HASH_W / BUS_W;
    localparam int CNT_W      = $clog2(LOAD_BYTES + HASH_BYTES + BPW + 1);
    localparam int HIW        = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
    localparam int PW         = (BPW > 1) ? $clog2(BPW) : 1;
    // Digest sits in the top HASH_W bits, the nonce trails it so WRITE is one shift register.
    localparam int SR_W       = HASH_W + WORD_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_HASH  = 3'd2,
        S_CHECK = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt_q;
    logic              mode_q;
    logic [TW-1:0]     target_q;
    logic [WORD_W-1:0] nonce_q;
    logic              rq_q;
    logic [SR_W-1:0]   out_sr;
    logic [WORD_W-1:0] hbuf [HDR_WORDS];

    logic              xfer;
    logic              last_ld;
    logic              last_wr;
    logic [CNT_W-1:0]  wr_last;
    logic [HIW-1:0]    ld_word;
    logic [PW-1:0]     ld_pos;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] sel_word;
    logic [HASH_W-1:0] hash_r;
    logic [TW-1:0]     lz;
    logic              lz_seen;
    logic              hit;
    logic              nonce_max;

    assign xfer      = host_rq && host_rdy;
    assign ld_word   = HIW'(cnt_q / CNT_W'(BPW));
    assign ld_pos    = PW'(cnt_q % CNT_W'(BPW));
    assign last_ld   = (cnt_q == CNT_W'(LOAD_BYTES - 1));
    assign wr_last   = mode_q ? CNT_W'(HASH_BYTES + BPW - 1) : CNT_W'(HASH_BYTES - 1);
    assign last_wr   = (cnt_q == wr_last);
    assign hash_r    = out_sr[SR_W-1 -: HASH_W];
    assign hit       = (lz >= target_q);
    assign nonce_max = &nonce_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_WRITE);

    // Header word as it looks after the incoming byte is merged (big-endian within the word).
    always_comb begin
        wr_word = hbuf[ld_word];
        wr_word[(BPW - 1 - int'(ld_pos)) * BUS_W +: BUS_W] = host_data;
    end

    // Word returned to the core: live nonce in sweep, zero past the header, else the cache.
    always_comb begin
        sel_word = '0;
        if (mode_q && (int'(core_addr) == NONCE_IDX)) begin
            sel_word = nonce_q;
        end else if (int'(core_addr) < HDR_WORDS) begin
            sel_word = hbuf[HIW'(core_addr)];
        end
    end

    // Leading-zero count of the latched digest; an all-zero digest counts as HASH_W.
    always_comb begin
        lz      = TW'(HASH_W);
        lz_seen = 1'b0;
        for (int i = HASH_W - 1; i >= 0; i--) begin
            if (!lz_seen && hash_r[i]) begin
                lz_seen = 1'b1;
                lz      = TW'(HASH_W - 1 - i);
            end
        end
    end

    // Status byte outside WRITE, current result byte during WRITE.
    always_comb begin
        host_out = '0;
        if (state_q == S_WRITE) begin
            host_out = out_sr[SR_W-1 -: BUS_W];
        end else begin
            host_out[3:0] = {busy, found, state_q[1:0]};
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (host_start) state_n = S_LOAD;
            S_LOAD:  if (xfer && last_ld) state_n = S_HASH;
            // core_done coinciding with a fresh start belongs to the previous hash.
            S_HASH:  if (core_done && !core_start) state_n = S_CHECK;
            S_CHECK: state_n = (!mode_q || hit || nonce_max) ? S_WRITE : S_HASH;
            S_WRITE: if (xfer && last_wr) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Handshakes, counters, nonce, result shift register and core word service.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_rq    <= 1'b0;
            found      <= 1'b0;
            core_start <= 1'b0;
            core_rdy   <= 1'b0;
            core_data  <= '0;
            cnt_q      <= '0;
            nonce_q    <= '0;
            mode_q     <= 1'b0;
            target_q   <= '0;
            rq_q       <= 1'b0;
            out_sr     <= '0;
        end else begin
            core_start <= (state_n == S_HASH) && (state_q != S_HASH);
            rq_q       <= core_rq;
            core_rdy   <= 1'b0;
            if ((state_q == S_HASH) && core_rq && !rq_q) begin
                core_rdy  <= 1'b1;
                core_data <= sel_word;
            end
            // Request drops for one cycle after every completed byte.
            if (((state_q == S_LOAD) || (state_q == S_WRITE)) && (state_n == state_q)) begin
                host_rq <= !xfer;
            end else begin
                host_rq <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (host_start) begin
                        mode_q   <= host_mode;
                        target_q <= host_target;
                        cnt_q    <= '0;
                        found    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_ld) begin
                            cnt_q   <= '0;
                            nonce_q <= (int'(ld_word) == NONCE_IDX) ? wr_word : hbuf[NONCE_IDX];
                        end
                    end
                end
                S_HASH: begin
                    if (core_done && !core_start) begin
                        out_sr[SR_W-1 -: HASH_W] <= core_hash;
                    end
                end
                S_CHECK: begin
                    if (state_n == S_WRITE) begin
                        found              <= hit;
                        out_sr[WORD_W-1:0] <= nonce_q;
                        cnt_q              <= '0;
                    end else begin
                        nonce_q <= nonce_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (xfer) begin
                        out_sr <= out_sr << BUS_W;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Header cache write; contents survive reset so a cached header stays usable.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_LOAD) && xfer) begin
            hbuf[ld_word] <= wr_word;
        end
    end

endmodule

// File: tb/tb_hash_host_bridge.sv
// tb/tb_hash_host_bridge.sv - table-driven bench for hash_host_bridge with host and core models
module tb_hash_host_bridge;

    logic         clk;
    logic         rst;
    logic         host_start;
    logic         host_mode;
    logic [8:0]   host_target;
    logic         host_rdy;
    logic [7:0]   host_data;
    logic         host_rq;
    logic [7:0]   host_out;
    logic         done;
    logic         found;
    logic         busy;
    logic         core_start;
    logic         core_rq;
    logic [4:0]   core_addr;
    logic         core_rdy;
    logic [31:0]  core_data;
    logic [255:0] core_hash;
    logic         core_done;

    hash_host_bridge dut (
        .clk(clk), .rst(rst),
        .host_start(host_start), .host_mode(host_mode), .host_target(host_target),
        .host_rdy(host_rdy), .host_data(host_data), .host_rq(host_rq), .host_out(host_out),
        .done(done), .found(found), .busy(busy),
        .core_start(core_start), .core_rq(core_rq), .core_addr(core_addr),
        .core_rdy(core_rdy), .core_data(core_data), .core_hash(core_hash), .core_done(core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [8:0]  tgt;
        logic [31:0] nonce;
        logic [31:0] hit;
        bit          zero;
        bit          stress;
        bit          poke;
        bit          exp_found;
        int          exp_starts;
        logic [31:0] exp_nonce;
    } vec_t;

    vec_t        vt [10];
    int          total;
    int          bad;
    logic [7:0]  hdr [80];
    logic [7:0]  rx [40];
    int          rx_n;
    int          drop_err;
    int          stab_err;

    bit          stress;
    logic [31:0] hit_g;
    bit          zero_g;
    logic [31:0] core_w [20];
    logic [31:0] data25;
    int          req_total;
    int          core_to;
    int          start_cycles;
    int          rdy_total;

    function automatic logic [255:0] model_hash(input logic [31:0] w0, input logic [31:0] w1,
                                                input logic [31:0] w18, input logic [31:0] w19,
                                                input logic [31:0] hit, input bit zero);
        logic [7:0] top;
        if (zero && (w19 == hit)) return '0;
        top = (w19 == hit) ? 8'h00 : 8'h40;
        return {top, w0[23:0] ^ 24'h5A5A5A, w19, w1 ^ w18, w19 + w0, ~w1, w18,
                32'hC0FFEE00 ^ w19, w0 ^ w19};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    always @(negedge clk) begin
        if (core_start) start_cycles <= start_cycles + 1;
        if (core_rdy) rdy_total <= rdy_total + 1;
    end

    // Behavioural core: fetch all header words on each start, then pulse done with a digest.
    initial begin
        bit got;
        int nreq;
        core_rq = 1'b0; core_addr = '0; core_hash = '0; core_done = 1'b0;
        req_total = 0; core_to = 0; data25 = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            if (core_start) begin
                nreq = stress ? 21 : 20;
                for (int r = 0; r < nreq; r++) begin
                    core_addr = (r == 20) ? 5'd25 : 5'(r);
                    core_rq = 1'b1;
                    req_total++;
                    got = 1'b0;
                    for (int t = 0; t < 30 && !got; t++) begin
                        @(negedge clk);
                        if (core_rdy) got = 1'b1;
                    end
                    if (!got) core_to++;
                    else if (r < 20) core_w[r] = core_data;
                    else data25 = core_data;
                    if (stress) repeat (9) @(negedge clk);
                    core_rq = 1'b0;
                    @(negedge clk);
                end
                core_hash = model_hash(core_w[0], core_w[1], core_w[18], core_w[19], hit_g, zero_g);
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    task automatic wait_rq(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (host_rq) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic send_bytes(input int from, input int to, input int maxd, input bit inv, output bit ok);
        for (int k = from; k < to; k++) begin
            wait_rq(ok);
            if (!ok) begin fail_to("load_rq"); return; end
            repeat ($urandom_range(maxd, 0)) @(negedge clk);
            host_data = inv ? ~hdr[k] : hdr[k];
            host_rdy = 1'b1;
            @(negedge clk);
            host_rdy = 1'b0;
            if (host_rq) drop_err++;
            if (maxd > 0) begin
                host_rdy = 1'b1; host_data = 8'hEE;
                @(negedge clk);
                host_rdy = 1'b0;
            end
        end
    endtask

    task automatic run_op(input vec_t v);
        int          b_st, b_rdy, b_req, d, mm;
        bit          ok;
        logic [7:0]  v0;
        logic [255:0] dig;
        logic [31:0] ew;
        hit_g = v.hit; zero_g = v.zero; stress = v.stress;
        for (int k = 0; k < 76; k++) hdr[k] = 8'(k);
        {hdr[76], hdr[77], hdr[78], hdr[79]} = v.nonce;
        drop_err = 0; stab_err = 0; rx_n = 0;
        b_st = start_cycles; b_rdy = rdy_total; b_req = req_total;
        @(negedge clk);
        host_start = 1'b1; host_mode = v.mode; host_target = v.tgt;
        @(negedge clk);
        host_start = 1'b0;
        send_bytes(0, 80, v.stress ? 5 : 0, 1'b0, ok);
        if (!ok) return;
        if (v.poke) begin
            host_start = 1'b1;
            @(negedge clk);
            host_start = 1'b0;
        end
        ok = 1'b0;
        for (int t = 0; t < 8000; t++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin fail_to("done_wait"); return; end
        for (int b = 0; b < 40; b++) begin
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                if (host_rq || !done) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            if (!ok) begin fail_to("write_rq"); return; end
            if (!done) break;
            v0 = host_out;
            d = v.stress ? $urandom_range(5, 0) : 0;
            repeat (d) begin
                @(negedge clk);
                if (host_out !== v0) stab_err++;
            end
            rx[b] = v0;
            rx_n++;
            host_rdy = 1'b1;
            @(negedge clk);
            host_rdy = 1'b0;
            if (host_rq) drop_err++;
            if (v.stress) begin
                host_rdy = 1'b1;
                @(negedge clk);
                host_rdy = 1'b0;
            end
        end
        @(negedge clk);
        dig = '0;
        for (int b = 0; b < 32; b++) dig = {dig[247:0], rx[b]};
        mm = 0;
        for (int i = 1; i < 19; i++) begin
            ew = {hdr[4*i], hdr[4*i+1], hdr[4*i+2], hdr[4*i+3]};
            if (core_w[i] !== ew) mm++;
        end
        chk("found", found, v.exp_found);
        chk("core_start_cycles", start_cycles - b_st, v.exp_starts);
        chk("byte_count", rx_n, v.mode ? 36 : 32);
        chk("digest", dig, model_hash(32'h00010203, 32'h04050607, 32'h48494A4B, v.exp_nonce, v.hit, v.zero));
        if (v.mode) chk("trailing_nonce", {rx[32], rx[33], rx[34], rx[35]}, v.exp_nonce);
        chk("core_word0", core_w[0], 32'h00010203);
        chk("core_word_nonce", core_w[19], v.exp_nonce);
        chk("core_words_mid", mm, 0);
        chk("core_rdy_per_req", rdy_total - b_rdy, req_total - b_req);
        chk("host_handshake", drop_err + stab_err, 0);
        chk("idle_status", host_out, v.exp_found ? 8'h04 : 8'h00);
        if (v.stress) chk("addr25_zero", data25, 32'h0);
    endtask

    initial begin
        bit ok;
        total = 0; bad = 0; stress = 1'b0; hit_g = '0; zero_g = 1'b0;
        start_cycles = 0; rdy_total = 0;
        rst = 1'b1; host_start = 1'b0; host_mode = 1'b0; host_target = '0;
        host_rdy = 1'b0; host_data = '0;

        //        mode  tgt    nonce          hit            zero st  poke fnd starts exp_nonce
        vt[0] = '{1'b0, 9'd0,   32'h4C4D4E4F, 32'h00000000, 0, 0, 0, 1, 1, 32'h4C4D4E4F};
        vt[1] = '{1'b0, 9'd1,   32'h4C4D4E4F, 32'h00000000, 0, 0, 0, 1, 1, 32'h4C4D4E4F};
        vt[2] = '{1'b0, 9'd2,   32'h4C4D4E4F, 32'h00000000, 0, 0, 0, 0, 1, 32'h4C4D4E4F};
        vt[3] = '{1'b1, 9'd8,   32'h00000010, 32'h00000013, 0, 0, 0, 1, 4, 32'h00000013};
        vt[4] = '{1'b1, 9'd300, 32'hFFFFFFFE, 32'h00000000, 0, 0, 0, 0, 2, 32'hFFFFFFFF};
        vt[5] = '{1'b1, 9'd256, 32'h00000020, 32'h00000020, 1, 0, 0, 1, 1, 32'h00000020};
        vt[6] = '{1'b0, 9'd256, 32'h4C4D4E4F, 32'h4C4D4E4F, 1, 0, 0, 1, 1, 32'h4C4D4E4F};
        vt[7] = '{1'b0, 9'd0,   32'h4C4D4E4F, 32'h00000000, 0, 1, 0, 1, 1, 32'h4C4D4E4F};
        vt[8] = '{1'b1, 9'd8,   32'h00000010, 32'h00000012, 0, 0, 1, 1, 3, 32'h00000012};
        vt[9] = '{1'b1, 9'd10,  32'hFFFFFFFD, 32'hFFFFFFFE, 0, 0, 0, 0, 3, 32'hFFFFFFFF};

        repeat (3) @(negedge clk);
        chk("rst_host_rq", host_rq, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_core_rdy", core_rdy, 1'b0);
        chk("rst_core_data", core_data, 32'h0);
        chk("rst_host_out", host_out, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_op(vt[i]);

        // Reset in the middle of a load, then a full reload from a fresh start.
        for (int k = 0; k < 80; k++) hdr[k] = 8'(k);
        stress = 1'b0;
        @(negedge clk);
        host_start = 1'b1; host_mode = 1'b0; host_target = 9'd0;
        @(negedge clk);
        host_start = 1'b0;
        send_bytes(0, 37, 0, 1'b1, ok);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_host_rq", host_rq, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_host_rq", host_rq, 1'b0);
        chk("after_rst_status", host_out, 8'h00);
        run_op(vt[0]);

        chk("core_timeouts", core_to, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hash_host_bridge.md
Name: hash_host_bridge

Overview:
- Parametrised byte-serial bridge between an external host and a double-SHA256 hash core.
- Loads a block header over a byte handshake and caches it, so the host sends it once.
- Feeds the cached header to the core on demand and streams the digest back to the host.
- Sweep mode adds autonomous nonce iteration, stopping on a leading-zero difficulty target or on nonce exhaustion.

Parameters:
- BUS_W, 8: host data bus width in bits.
- WORD_W, 32: core data word width; must be a multiple of BUS_W.
- HDR_WORDS, 20: header words cached; the load length is HDR_WORDS*WORD_W/BUS_W bytes.
- HASH_W, 256: digest width; must be a multiple of BUS_W.
- NONCE_IDX, 19: header word index holding the nonce.
- AW, 5: core address width; 2^AW must be >= HDR_WORDS.
- TW, 9: target width; must be >= clog2(HASH_W+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- host_start  in  1  begin an operation; sampled only in IDLE.
- host_mode  in  1  latched at start; 0 = single hash, 1 = nonce sweep.
- host_target  in  TW  required leading-zero bit count; latched at start.
- host_rdy  in  1  host completes the current byte transfer.
- host_data  in  BUS_W  header byte from the host.
- host_rq  out  1  bridge requests a byte transfer.
- host_out  out  BUS_W  result byte in WRITE, status otherwise.
- done  out  1  high for the whole of WRITE.
- found  out  1  sweep result flag.
- busy  out  1  high whenever state != IDLE.
- core_start  out  1  one-cycle start pulse to the core.
- core_rq  in  1  core word request (level).
- core_addr  in  AW  requested word index.
- core_rdy  out  1  one-cycle pulse: core_data is valid.
- core_data  out  WORD_W  supplied word.
- core_hash  in  HASH_W  digest; valid while core_done is high.
- core_done  in  1  digest valid.

Behaviour:
- Reset values: state=IDLE; host_rq, done, found, busy, core_start, core_rdy all 0; core_data=0; byte and nonce counters 0. Header buffer is not reset.
- States:
  - IDLE: on host_start, latch mode and target, clear the byte counter, go to LOAD. host_start in any other state is ignored.
  - LOAD: host_rq rises the cycle after the counter leaves idle.
    - A transfer completes on a cycle with host_rq && host_rdy; host_rq drops the next cycle and re-asserts the cycle after that.
    - Bytes arrive big-endian within each word, word 0 first, into buf[k/(WORD_W/BUS_W)].
    - After the last byte: nonce := buf[NONCE_IDX], go to HASH.
  - HASH: core_start is high for exactly the first cycle of HASH.
    - Rising edge of core_rq (registered previous value was 0) latches core_addr.
    - Next cycle: core_data = the word at that address and core_rdy=1 for one cycle.
    - Word selection: in sweep mode, addr==NONCE_IDX returns the live nonce; addr >= HDR_WORDS returns 0; otherwise buf[addr].
    - core_rdy pulses exactly once per rising edge. A level-held core_rq never re-triggers.
    - On core_done, go to CHECK.
  - CHECK (1 cycle): lz = leading zero count of core_hash (MSB = bit HASH_W-1); all-zero hash gives lz = HASH_W. Latch core_hash into the result register.
    - Single mode: found := (lz >= target), go to WRITE.
    - Sweep mode, lz >= target: found=1, go to WRITE.
    - Sweep mode, nonce == 2^WORD_W-1: found=0, go to WRITE.
    - Otherwise: nonce := nonce+1, go to HASH with a fresh core_start. No reload from the host.
  - WRITE: done=1. Same rq/rdy rules as LOAD.
    - Sends HASH_W/BUS_W bytes of the latched hash, MSB byte first.
    - Sweep mode then also sends WORD_W/BUS_W nonce bytes, MSB first.
    - host_out holds the current byte stable while host_rq is high.
    - After the final transfer: done=0 next cycle, state=IDLE. found holds until the next host_start.
- host_out outside WRITE: {zero pad, busy, found, state[1:0]} in the low bits.
- Simultaneous host_rdy with host_rq low: ignored.
- Reset asserted in any state: returns to IDLE on the next edge and drops all pulses. The core is reset separately.
- Target > HASH_W: can never be met; sweep runs to exhaustion.

Test Plan:
- Single mode, header bytes 0x00..0x4F, target 0, behavioural core model → 80 host_rq transfers; core receives buf[0]=0x00010203 and buf[19]=0x4C4D4E4F; found=1; 32 digest bytes MSB-first match the model; no nonce bytes sent.
- Sweep mode, nonce word 0x00000010, model hash has lz>=8 only when nonce=0x00000013, target 8 → exactly 4 core_start pulses; found=1; trailing bytes 00 00 00 13.
- Sweep exhaustion: nonce 0xFFFFFFFE, target 300 → 2 hashes; found=0; trailing nonce bytes FF FF FF FF; no wrap to 0.
- Handshake stress: host_rdy randomly delayed 0–5 cycles; core holds core_rq high 10 cycles per request → one byte per rq/rdy pair; one core_rdy per core_rq rising edge; core_addr 25 returns 0.
- host_start pulsed during HASH → ignored; reset asserted mid-LOAD after 37 bytes → next cycle IDLE with host_rq=0; a fresh start reloads all 80 bytes.
